// File: rtl/square_game_pkg.sv
// Shared encodings and geometry constants for the square-chasing game.
package square_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } game_state_e;

    localparam int PLAYER_HALF    = 25;
    localparam int TARGET_HALF    = 30;
    localparam int CONTAIN_MARGIN = 5;
    localparam int SPAWN_OFFSET   = 30;
    localparam int RESET_X        = 320;
    localparam int RESET_Y        = 240;

endpackage

// File: rtl/target_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) used for target placement.
module target_lfsr16 (
    input  logic        clk_25mHz,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic fb;

    // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
    assign fb = state[0] ^ state[2] ^ state[3] ^ state[5];

    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            state <= seed;
        end else begin
            state <= {fb, state[15:1]};
        end
    end

endmodule

// File: rtl/target_game_ctrl.sv
// Target game controller: frame-ticked dwell/score FSM with random respawn.
// Define TARGET_TIMEOUT_EN to enable the per-target timeout and life loss.
module target_game_ctrl
    import square_game_pkg::*;
#(
    parameter int          DWELL_FRAMES   = 30,
    parameter int          TIMEOUT_FRAMES = 300,
    parameter int          START_LIVES    = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk_25mHz,
    input  logic        reset,
    input  logic        screenEnd,
    input  logic        start_btn,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    output logic [31:0] target_x,
    output logic [31:0] target_y,
    output logic [31:0] game_state,
    output logic [31:0] lives,
    output logic [15:0] score
);

    if (DWELL_FRAMES < 1 || TIMEOUT_FRAMES < 1 || LFSR_SEED == 16'h0000) begin : g_param_check
        $error("target_game_ctrl: frame counts must be >= 1 and LFSR_SEED non-zero");
    end

    logic        screen_q, screen_q2;
    logic        btn_s1, btn_s2, btn_s3;
    logic        frame_tick, start_ev;
    logic [15:0] lfsr;
    game_state_e state;
    logic [9:0]  tx;
    logic [8:0]  ty;
    logic [31:0] lives_q;
    logic [15:0] score_q;
    logic [31:0] dwell, dwell_inc;
    logic [9:0]  spawn_x;
    logic [8:0]  spawn_y;
    logic signed [10:0] dx, dy;
    logic        contained, hit;
`ifdef TARGET_TIMEOUT_EN
    logic [31:0] timer, timer_inc;
    logic        timeout;
`endif

    function automatic logic within_margin(input logic signed [10:0] d);
        return (d <= $signed(11'(CONTAIN_MARGIN))) && (d >= -$signed(11'(CONTAIN_MARGIN)));
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    target_lfsr16 u_lfsr (
        .clk_25mHz (clk_25mHz),
        .reset     (reset),
        .seed      (LFSR_SEED),
        .state     (lfsr)
    );

    assign frame_tick = screen_q & ~screen_q2;
    assign start_ev   = btn_s2 & ~btn_s3;

    // Zero-extended 11-bit differences cannot wrap for 10/9-bit coordinates.
    assign dx        = $signed({1'b0, player_x}) - $signed({1'b0, tx});
    assign dy        = $signed({2'b0, player_y}) - $signed({2'b0, ty});
    assign contained = within_margin(dx) && within_margin(dy);
    assign dwell_inc = dwell + 32'd1;
    assign hit       = contained && (dwell_inc == 32'(DWELL_FRAMES));

    assign spawn_x = 10'(SPAWN_OFFSET) + {1'b0, lfsr[8:0]};
    assign spawn_y = 9'(SPAWN_OFFSET) + {1'b0, lfsr[15:8]} + {2'b0, lfsr[6:0]};

`ifdef TARGET_TIMEOUT_EN
    assign timer_inc = timer + 32'd1;
    assign timeout   = (timer_inc == 32'(TIMEOUT_FRAMES));
`endif

    always_ff @(posedge clk_25mHz or negedge reset) begin
        if (!reset) begin
            screen_q  <= 1'b0;
            screen_q2 <= 1'b0;
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_s3    <= 1'b0;
            state     <= ST_IDLE;
            tx        <= 10'(RESET_X);
            ty        <= 9'(RESET_Y);
            lives_q   <= '0;
            score_q   <= '0;
            dwell     <= '0;
`ifdef TARGET_TIMEOUT_EN
            timer     <= '0;
`endif
        end else begin
            screen_q  <= screenEnd;
            screen_q2 <= screen_q;
            btn_s1    <= start_btn;
            btn_s2    <= btn_s1;
            btn_s3    <= btn_s2;
            case (state)
                ST_IDLE: begin
                    if (start_ev) begin
                        state   <= ST_PLAY;
                        lives_q <= 32'(START_LIVES);
                        score_q <= '0;
                        dwell   <= '0;
`ifdef TARGET_TIMEOUT_EN
                        timer   <= '0;
`endif
                        tx      <= spawn_x;
                        ty      <= spawn_y;
                    end
                end
                ST_PLAY: begin
                    if (frame_tick) begin
                        // A hit on the same tick as a timeout takes priority.
                        if (hit) begin
                            score_q <= sat_inc16(score_q);
                            dwell   <= '0;
`ifdef TARGET_TIMEOUT_EN
                            timer   <= '0;
`endif
                            tx      <= spawn_x;
                            ty      <= spawn_y;
                        end else begin
                            dwell <= contained ? dwell_inc : '0;
`ifdef TARGET_TIMEOUT_EN
                            timer <= timer_inc;
                            if (timeout) begin
                                lives_q <= lives_q - 32'd1;
                                dwell   <= '0;
                                timer   <= '0;
                                tx      <= spawn_x;
                                ty      <= spawn_y;
                                if (lives_q == 32'd1) begin
                                    state <= ST_OVER;
                                end
                            end
`endif
                        end
                    end
                end
                ST_OVER: begin
                    if (start_ev) begin
                        state   <= ST_IDLE;
                        lives_q <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign target_x   = {22'd0, tx};
    assign target_y   = {23'd0, ty};
    assign game_state = {30'd0, state};
    assign lives      = lives_q;
    assign score      = score_q;

endmodule
